// File: rtl/instruction_sequencer.sv
// ----------------------------------------------------------------------------
// instruction_sequencer
//
// Control stage in front of the Aeolus register file and shift register.
// Takes 8-bit instruction words ({opcode[7:4], operand[3:0]}) over a
// valid/ready handshake and sequences the multi-cycle load/ALU/shift strobes.
//
// Handshake: a word is accepted on the rising edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE. A valid word offered
// while instr_ready is 0 is dropped, because nothing is queued. The producer
// may change or withdraw instr_valid at any time.
//
// Optional feature (macro SEQ_ILLEGAL_TRAP_EN): an illegal opcode parks the
// FSM in HALT, with instr_ready=0 and no done, until reset. When the macro is
// undefined, an illegal opcode retires like a NOP and sets err.
//
// Ports:
//   clk          system clock; everything is on posedge
//   reset        asynchronous active-low reset
//   instr_in     instruction word {opcode, operand}
//   instr_valid  instr_in is valid
//   instr_ready  sequencer is in IDLE and can accept
//   operand_out  operand presented to register/shift inputs (held outside LOAD)
//   lda/ldb/ldo  register A/B/O load strobes
//   alu_op       00 ADD, 01 SUB, 10 MUL (held through EXEC and WRITE)
//   shift_load   shift-register load enable
//   shift_state  10 LSH, 01 RSH, 00 hold
//   done         one-cycle pulse when an instruction retires
//   err          sticky illegal-opcode flag
//   dbg_state    current FSM state, for debug/observation
// ----------------------------------------------------------------------------
module instruction_sequencer #(
    parameter int ALU_LATENCY = 2,
    parameter int DATA_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            instr_in,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] operand_out,
    output logic                  lda,
    output logic                  ldb,
    output logic                  ldo,
    output logic [1:0]            alu_op,
    output logic                  shift_load,
    output logic [1:0]            shift_state,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_LOAD   = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
`ifdef SEQ_ILLEGAL_TRAP_EN
        S_SHIFT  = 3'd5,
        S_HALT   = 3'd6
`else
        S_SHIFT  = 3'd5
`endif
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h5;
    localparam logic [3:0] OP_LSH = 4'h6;
    localparam logic [3:0] OP_RSH = 4'h7;
    localparam logic [3:0] OP_LDS = 4'h8;

    localparam logic [3:0] ALU_CNT_INIT = 4'(ALU_LATENCY - 1);

    state_t                r_state;
    logic [7:0]            r_instr;
    logic [3:0]            r_cnt;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_operand;
    logic                  r_lda;
    logic                  r_ldb;
    logic                  r_ldo;
    logic [1:0]            r_alu_op;
    logic                  r_shift_load;
    logic [1:0]            r_shift_state;
    logic                  r_done;
    logic                  r_err;

    state_t                w_next_state;
    logic [3:0]            w_cnt_next;
    logic                  w_done_next;
    logic                  w_err_next;
    logic                  w_accept;
    logic [3:0]            w_opcode;
    logic [3:0]            w_operand;
    logic [1:0]            w_alu_code;
    logic [1:0]            w_shift_dir;

    assign w_opcode  = r_instr[7:4];
    assign w_operand = r_instr[3:0];
    assign w_accept  = (r_state == S_IDLE) && instr_valid && r_ready;

    always_comb begin
        w_alu_code = 2'b00;
        case (w_opcode)
            OP_SUB:  w_alu_code = 2'b01;
            OP_MUL:  w_alu_code = 2'b10;
            default: w_alu_code = 2'b00;
        endcase
    end

    assign w_shift_dir = (w_opcode == OP_LSH) ? 2'b10 : 2'b01;

    // Next-state logic. The counter is loaded with (length - 1) on entry to
    // EXEC/SHIFT so that the state lasts exactly "length" cycles.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        w_err_next   = r_err;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                case (w_opcode)
                    OP_NOP: begin
                        w_next_state = S_IDLE;
                        w_done_next  = 1'b1;
                    end
                    OP_LDA, OP_LDB, OP_LDS: w_next_state = S_LOAD;
                    OP_ADD, OP_SUB, OP_MUL: begin
                        w_next_state = S_EXEC;
                        w_cnt_next   = ALU_CNT_INIT;
                    end
                    OP_LSH, OP_RSH: begin
                        if (w_operand != 4'd0) begin
                            w_next_state = S_SHIFT;
                            w_cnt_next   = w_operand - 4'd1;
                        end else begin
                            w_next_state = S_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end
                    default: begin
                        w_err_next = 1'b1;
`ifdef SEQ_ILLEGAL_TRAP_EN
                        w_next_state = S_HALT;
`else
                        w_next_state = S_IDLE;
                        w_done_next  = 1'b1;
`endif
                    end
                endcase
            end
            S_LOAD: begin
                w_next_state = S_IDLE;
                w_done_next  = 1'b1;
            end
            S_EXEC: begin
                if (r_cnt == 4'd0) w_next_state = S_WRITE;
                else               w_cnt_next   = r_cnt - 4'd1;
            end
            S_WRITE: begin
                w_next_state = S_IDLE;
                w_done_next  = 1'b1;
            end
            S_SHIFT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_IDLE;
                    w_done_next  = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
`ifdef SEQ_ILLEGAL_TRAP_EN
            S_HALT: w_next_state = S_HALT;
`endif
            default: w_next_state = S_IDLE;
        endcase
    end

    // State and registered outputs. Each output is computed from the state
    // being entered, so it lines up exactly with that state's cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_instr       <= 8'h00;
            r_cnt         <= 4'd0;
            r_ready       <= 1'b0;
            r_operand     <= '0;
            r_lda         <= 1'b0;
            r_ldb         <= 1'b0;
            r_ldo         <= 1'b0;
            r_alu_op      <= 2'b00;
            r_shift_load  <= 1'b0;
            r_shift_state <= 2'b00;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_accept) r_instr <= instr_in;
            r_ready      <= (w_next_state == S_IDLE);
            r_lda        <= (w_next_state == S_LOAD) && (w_opcode == OP_LDA);
            r_ldb        <= (w_next_state == S_LOAD) && (w_opcode == OP_LDB);
            r_shift_load <= (w_next_state == S_LOAD) && (w_opcode == OP_LDS);
            r_ldo        <= (w_next_state == S_WRITE);
            r_alu_op     <= ((w_next_state == S_EXEC) || (w_next_state == S_WRITE))
                            ? w_alu_code : 2'b00;
            r_shift_state <= (w_next_state == S_SHIFT) ? w_shift_dir : 2'b00;
            if (w_next_state == S_LOAD) r_operand <= DATA_WIDTH'(w_operand);
            r_done <= w_done_next;
            r_err  <= w_err_next;
        end
    end

    assign instr_ready = r_ready;
    assign operand_out = r_operand;
    assign lda         = r_lda;
    assign ldb         = r_ldb;
    assign ldo         = r_ldo;
    assign alu_op      = r_alu_op;
    assign shift_load  = r_shift_load;
    assign shift_state = r_shift_state;
    assign done        = r_done;
    assign err         = r_err;
    assign dbg_state   = r_state;

endmodule
